rom_dl_bridge: RTL and testbench
================================

ROM_DL_BRIDGE -- requirements
Module: rom_dl_bridge

Interface
REQ-001 Parameter INDEX, default 8'd0: ioctl_index value whose bytes are accepted; all other indices are ignored.
REQ-002 Parameter FIFO_DEPTH, default 4: number of pending SDRAM write entries; SHALL be a power of two and at least 2.
REQ-003 clk_sys  in  1  single clock; all logic is on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 ioctl_download  in  1  download window from data_io.
REQ-006 ioctl_index  in  8  download target index.
REQ-007 ioctl_wr  in  1  byte strobe; may stay high for several cycles; rising edges are at least 4 cycles apart.
REQ-008 ioctl_addr  in  25  byte address; only bits [23:0] are used.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 port1_req  out  1  SDRAM request toggle.
REQ-011 port1_ack  in  1  SDRAM acknowledge toggle; a request completes when port1_ack equals port1_req.
REQ-012 port1_a  out  23  SDRAM word address.
REQ-013 port1_ds  out  2  byte enables {upper, lower}.
REQ-014 port1_d  out  16  write data.
REQ-015 port1_we  out  1  write enable.
REQ-016 rom_loaded  out  1  ROM image complete; used to release the core reset.
REQ-017 overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-018 Bytes SHALL be accepted only on a rising edge of ioctl_wr while ioctl_download=1 and ioctl_index=INDEX.
REQ-019 Word address SHALL be ioctl_addr[23:1]; the byte lane SHALL be ioctl_addr[0] (1 = upper, bits [15:8]).
REQ-020 Hold register: an accepted even-lane byte SHALL be stored, with its word address, in the hold register.
REQ-021 Merge: an odd-lane byte whose word address matches a valid hold SHALL push one FIFO entry with ds=2'b11, d={odd,even}, and clear the hold.
REQ-022 Non-merge: an odd byte without a matching hold SHALL push a partial entry with ds=2'b10 and d={byte,byte}; any stale hold SHALL be pushed first as ds=2'b01, d={byte,byte}.
REQ-023 Push timing: at most one FIFO push per cycle; a second required push SHALL occur in the next cycle, before the next byte can arrive (guaranteed by REQ-007).
REQ-024 Flush: on the falling edge of ioctl_download, a valid hold SHALL be pushed as a partial ds=2'b01 entry.
REQ-025 FIFO full at push time: the entry SHALL be dropped and overflow set to 1 until reset.
REQ-026 Issue FSM states: IDLE and WAIT.
  - IDLE, FIFO non-empty, port1_ack==port1_req: pop the entry into port1_a/ds/d, toggle port1_req, go to WAIT.
  - WAIT: hold all outputs stable until port1_ack==port1_req, then go to IDLE.
REQ-027 Throughput: in IDLE, the first entry pushed into an empty FIFO SHALL be issued no earlier than the cycle after the push, giving a 1-cycle latency from push to toggle.
REQ-028 port1_we SHALL be 1 whenever ioctl_download=1, the FIFO is non-empty, the hold is valid, or the FSM is in WAIT.
REQ-029 A rising edge of ioctl_download with a matching index SHALL clear rom_loaded.
REQ-030 rom_loaded SHALL be set to 1 one cycle after all of the following hold:
  - the download has ended;
  - the hold is empty;
  - the FIFO is empty;
  - the FSM is in IDLE with port1_ack==port1_req.
REQ-031 A download with a non-matching index SHALL leave rom_loaded and the FIFO unchanged.

Reset
REQ-032 On reset_n=0, asynchronously:
  - port1_req, port1_a, port1_ds, port1_d, port1_we, rom_loaded and overflow go to 0;
  - the FIFO pointers, the hold, the edge-detect registers and the FSM (IDLE) are cleared.
REQ-033 After reset release, no request SHALL be issued while port1_ack differs from port1_req; a reset in mid-transfer discards pending entries.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the FIFO entry struct {a[22:0], ds[1:0], d[15:0]}, and the DS_LO, DS_HI and DS_BOTH constants.
REQ-035 The FIFO SHALL be one sub-module, dl_fifo: synchronous, single clock, with full and empty outputs.

Verification
REQ-036 Bytes 0x11@0, 0x22@1 -> one request: a=0, ds=11, d=0x2211; one req toggle.
REQ-037 Byte 0xAB@5, then download ends -> one request: a=2, ds=10, d=0xABAB; rom_loaded=1 after ack.
REQ-038 Byte 0x33@4, then download ends -> flush request: a=2, ds=01, d=0x3333.
REQ-039 port1_ack held for 20 cycles with 6 words queued -> overflow=1; exactly FIFO_DEPTH+1 requests issued; outputs stable during WAIT.
REQ-040 ioctl_index=1 with INDEX=0 -> no requests; rom_loaded unchanged.
REQ-041 reset_n pulsed low during WAIT -> all outputs 0 immediately; no toggle until ack==req.

Source files
------------

// File: rtl/rom_dl_bridge_pkg.sv
// Shared types for the ROM download bridge: issue FSM states, the pending
// SDRAM write entry and the byte-enable encodings.
package rom_dl_bridge_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } dl_entry_t;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = 2'b11;

    function automatic dl_entry_t make_entry(input logic [22:0] a,
                                             input logic [1:0]  ds,
                                             input logic [15:0] d);
        dl_entry_t e;
        e.a  = a;
        e.ds = ds;
        e.d  = d;
        return e;
    endfunction

endpackage

// File: rtl/dl_fifo.sv
// Small show-ahead FIFO of pending SDRAM write entries. Head entry is visible
// on rdata_o whenever empty_o is low so the issuer can pop and launch together.
module dl_fifo
    import rom_dl_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_sys,
    input  logic      reset_n,
    input  logic      push_i,
    input  dl_entry_t wdata_i,
    input  logic      pop_i,
    output dl_entry_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    dl_entry_t      mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_dl_bridge.sv
// Bridges data_io byte downloads to a 16-bit SDRAM port: pairs bytes into words,
// queues them and issues toggle-handshake writes; flags when the ROM is loaded.
module rom_dl_bridge
    import rom_dl_bridge_pkg::*;
#(
    parameter logic [7:0] INDEX      = 8'd0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port1_we,
    output logic        rom_loaded,
    output logic        overflow
);

    logic         wr_q;
    logic         dl_q;
    logic         dl_seen_q;
    logic         loaded_q;
    logic         overflow_q;
    logic         we_q;

    logic         hold_valid_q, hold_valid_d;
    logic [22:0]  hold_a_q, hold_a_d;
    logic [7:0]   hold_b_q, hold_b_d;
    logic         pend_valid_q, pend_valid_d;
    dl_entry_t    pend_q, pend_d;

    issue_state_e state_q, state_d;
    logic         req_q, req_d;
    logic [22:0]  a_q, a_d;
    logic [1:0]   ds_q, ds_d;
    logic [15:0]  d_q, d_d;

    logic         push;
    dl_entry_t    push_entry;
    logic         pop;
    dl_entry_t    fifo_head;
    logic         fifo_full;
    logic         fifo_empty;

    logic         index_match;
    logic         accept;
    logic         dl_rise;
    logic [22:0]  byte_waddr;
    logic         ack_match;
    logic         load_done;
    logic         unused_addr_msb;

    assign unused_addr_msb = ioctl_addr[24];
    assign index_match     = (ioctl_index == INDEX);
    assign accept          = ioctl_wr && !wr_q && ioctl_download && index_match;
    assign dl_rise         = ioctl_download && !dl_q && index_match;
    assign byte_waddr      = ioctl_addr[23:1];
    assign ack_match       = (port1_ack == req_q);

    // Byte pairing. A pending second push always drains before the next byte,
    // since ioctl_wr rising edges are several cycles apart.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_a_d     = hold_a_q;
        hold_b_d     = hold_b_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        push         = 1'b0;
        push_entry   = '0;
        if (pend_valid_q) begin
            push         = 1'b1;
            push_entry   = pend_q;
            pend_valid_d = 1'b0;
        end else if (accept) begin
            if (ioctl_addr[0]) begin
                push = 1'b1;
                if (hold_valid_q && (hold_a_q == byte_waddr)) begin
                    push_entry   = make_entry(byte_waddr, DS_BOTH, {ioctl_dout, hold_b_q});
                    hold_valid_d = 1'b0;
                end else if (hold_valid_q) begin
                    push_entry   = make_entry(hold_a_q, DS_LO, {hold_b_q, hold_b_q});
                    hold_valid_d = 1'b0;
                    pend_valid_d = 1'b1;
                    pend_d       = make_entry(byte_waddr, DS_HI, {ioctl_dout, ioctl_dout});
                end else begin
                    push_entry   = make_entry(byte_waddr, DS_HI, {ioctl_dout, ioctl_dout});
                end
            end else begin
                if (hold_valid_q) begin
                    push       = 1'b1;
                    push_entry = make_entry(hold_a_q, DS_LO, {hold_b_q, hold_b_q});
                end
                hold_valid_d = 1'b1;
                hold_a_d     = byte_waddr;
                hold_b_d     = ioctl_dout;
            end
        end else if (!ioctl_download && hold_valid_q) begin
            push         = 1'b1;
            push_entry   = make_entry(hold_a_q, DS_LO, {hold_b_q, hold_b_q});
            hold_valid_d = 1'b0;
        end
    end

    dl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        a_d     = a_q;
        ds_d    = ds_q;
        d_d     = d_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && ack_match) begin
                    pop     = 1'b1;
                    a_d     = fifo_head.a;
                    ds_d    = fifo_head.ds;
                    d_d     = fifo_head.d;
                    req_d   = ~req_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ack_match) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_done = dl_seen_q && !ioctl_download && !hold_valid_q && !pend_valid_q &&
                       fifo_empty && (state_q == ST_IDLE) && ack_match;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q         <= 1'b0;
            dl_q         <= 1'b0;
            dl_seen_q    <= 1'b0;
            loaded_q     <= 1'b0;
            overflow_q   <= 1'b0;
            we_q         <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_a_q     <= '0;
            hold_b_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            a_q          <= '0;
            ds_q         <= '0;
            d_q          <= '0;
        end else begin
            wr_q         <= ioctl_wr;
            dl_q         <= ioctl_download;
            hold_valid_q <= hold_valid_d;
            hold_a_q     <= hold_a_d;
            hold_b_q     <= hold_b_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            state_q      <= state_d;
            req_q        <= req_d;
            a_q          <= a_d;
            ds_q         <= ds_d;
            d_q          <= d_d;
            we_q         <= ioctl_download || !fifo_empty || hold_valid_q ||
                            pend_valid_q || (state_q == ST_WAIT);
            if (push && fifo_full) begin
                overflow_q <= 1'b1;
            end
            // Only a matching download arms the loaded flag, so a fresh reset
            // keeps the core held until a ROM image has actually arrived.
            if (dl_rise) begin
                dl_seen_q <= 1'b1;
                loaded_q  <= 1'b0;
            end else if (load_done) begin
                loaded_q  <= 1'b1;
            end
        end
    end

    assign port1_req  = req_q;
    assign port1_a    = a_q;
    assign port1_ds   = ds_q;
    assign port1_d    = d_q;
    assign port1_we   = we_q;
    assign rom_loaded = loaded_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_dl_bridge.sv
// Directed bench for rom_dl_bridge: a delayed-ack SDRAM responder, a request
// logger, and one task per scenario with hand-computed expected requests.
module tb_rom_dl_bridge;

    localparam int ACK_DLY = 2;

    logic        clk_sys;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        port1_req;
    logic        port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port1_we;
    logic        rom_loaded;
    logic        overflow;

    int checks;
    int failures;
    int req_cnt;
    int stab_err;
    int ack_cnt;
    logic ack_hold;
    logic ack_poke;
    logic req_seen;
    logic stab_armed;
    logic [22:0] last_a;
    logic [1:0]  last_ds;
    logic [15:0] last_d;
    logic [22:0] log_a[$];
    logic [1:0]  log_ds[$];
    logic [15:0] log_d[$];
    logic        log_we[$];

    rom_dl_bridge dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .port1_req      (port1_req),
        .port1_ack      (port1_ack),
        .port1_a        (port1_a),
        .port1_ds       (port1_ds),
        .port1_d        (port1_d),
        .port1_we       (port1_we),
        .rom_loaded     (rom_loaded),
        .overflow       (overflow)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // SDRAM responder: answers a pending toggle after ACK_DLY cycles unless held.
    initial begin
        port1_ack = 1'b0;
        ack_cnt   = 0;
        forever begin
            @(posedge clk_sys);
            #2;
            if (ack_poke) begin
                port1_ack = 1'b1;
            end else if (!ack_hold && (port1_ack !== port1_req)) begin
                if (ack_cnt >= ACK_DLY) begin
                    port1_ack = port1_req;
                    ack_cnt   = 0;
                end else begin
                    ack_cnt++;
                end
            end
        end
    end

    // Request logger plus stability watch while a request is outstanding.
    initial begin
        req_seen   = 1'b0;
        stab_armed = 1'b0;
        req_cnt    = 0;
        stab_err   = 0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                req_seen   = 1'b0;
                stab_armed = 1'b0;
            end else if (port1_req !== req_seen) begin
                req_seen   = port1_req;
                stab_armed = 1'b1;
                last_a     = port1_a;
                last_ds    = port1_ds;
                last_d     = port1_d;
                log_a.push_back(port1_a);
                log_ds.push_back(port1_ds);
                log_d.push_back(port1_d);
                log_we.push_back(port1_we);
                req_cnt++;
                $display("req #%0d a=%h ds=%b d=%h we=%b", req_cnt, port1_a, port1_ds, port1_d, port1_we);
            end else if (stab_armed && (port1_req !== port1_ack)) begin
                if (port1_a !== last_a || port1_ds !== last_ds ||
                    port1_d !== last_d || port1_we !== 1'b1) begin
                    stab_err++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_log();
        log_a.delete();
        log_ds.delete();
        log_d.delete();
        log_we.delete();
    endtask

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
        tick(1);
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        tick(2);
        ioctl_wr   = 1'b0;
        tick(1);
    endtask

    task automatic dl_begin(input logic [7:0] idx);
        tick(1);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick(2);
    endtask

    task automatic dl_end();
        tick(1);
        ioctl_download = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        checks++; if (port1_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", port1_req); end
        checks++; if (port1_a !== 23'd0) begin failures++; $display("FAIL reset_a got=%h exp=0", port1_a); end
        checks++; if (port1_ds !== 2'b00) begin failures++; $display("FAIL reset_ds got=%b exp=00", port1_ds); end
        checks++; if (port1_d !== 16'h0000) begin failures++; $display("FAIL reset_d got=%h exp=0000", port1_d); end
        checks++; if (port1_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", port1_we); end
        checks++; if (rom_loaded !== 1'b0) begin failures++; $display("FAIL reset_loaded got=%b exp=0", rom_loaded); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        reset_n = 1'b1;
        tick(5);
        checks++; if (req_cnt !== 0) begin failures++; $display("FAIL reset_no_req got=%0d exp=0", req_cnt); end
    endtask

    task automatic test_merge();
        clear_log();
        dl_begin(8'd0);
        send_byte(25'd0, 8'h11);
        send_byte(25'd1, 8'h22);
        tick(20);
        checks++; if (log_a.size() !== 1) begin failures++; $display("FAIL merge_count got=%0d exp=1", log_a.size()); end
        checks++; if (log_a[0] !== 23'd0) begin failures++; $display("FAIL merge_a got=%h exp=0", log_a[0]); end
        checks++; if (log_ds[0] !== 2'b11) begin failures++; $display("FAIL merge_ds got=%b exp=11", log_ds[0]); end
        checks++; if (log_d[0] !== 16'h2211) begin failures++; $display("FAIL merge_d got=%h exp=2211", log_d[0]); end
        checks++; if (log_we[0] !== 1'b1) begin failures++; $display("FAIL merge_we got=%b exp=1", log_we[0]); end
        dl_end();
        tick(20);
        checks++; if (rom_loaded !== 1'b1) begin failures++; $display("FAIL merge_loaded got=%b exp=1", rom_loaded); end
    endtask

    task automatic test_odd_only();
        clear_log();
        dl_begin(8'd0);
        checks++; if (rom_loaded !== 1'b0) begin failures++; $display("FAIL odd_loaded_clear got=%b exp=0", rom_loaded); end
        send_byte(25'd5, 8'hAB);
        dl_end();
        tick(20);
        checks++; if (log_a.size() !== 1) begin failures++; $display("FAIL odd_count got=%0d exp=1", log_a.size()); end
        checks++; if (log_a[0] !== 23'd2) begin failures++; $display("FAIL odd_a got=%h exp=2", log_a[0]); end
        checks++; if (log_ds[0] !== 2'b10) begin failures++; $display("FAIL odd_ds got=%b exp=10", log_ds[0]); end
        checks++; if (log_d[0] !== 16'hABAB) begin failures++; $display("FAIL odd_d got=%h exp=abab", log_d[0]); end
        checks++; if (rom_loaded !== 1'b1) begin failures++; $display("FAIL odd_loaded got=%b exp=1", rom_loaded); end
    endtask

    task automatic test_flush();
        clear_log();
        dl_begin(8'd0);
        send_byte(25'd4, 8'h33);
        tick(10);
        checks++; if (log_a.size() !== 0) begin failures++; $display("FAIL flush_held got=%0d exp=0", log_a.size()); end
        dl_end();
        tick(20);
        checks++; if (log_a.size() !== 1) begin failures++; $display("FAIL flush_count got=%0d exp=1", log_a.size()); end
        checks++; if (log_a[0] !== 23'd2) begin failures++; $display("FAIL flush_a got=%h exp=2", log_a[0]); end
        checks++; if (log_ds[0] !== 2'b01) begin failures++; $display("FAIL flush_ds got=%b exp=01", log_ds[0]); end
        checks++; if (log_d[0] !== 16'h3333) begin failures++; $display("FAIL flush_d got=%h exp=3333", log_d[0]); end
        checks++; if (rom_loaded !== 1'b1) begin failures++; $display("FAIL flush_loaded got=%b exp=1", rom_loaded); end
    endtask

    task automatic test_stale_hold();
        clear_log();
        dl_begin(8'd0);
        send_byte(25'd6, 8'h44);
        send_byte(25'd9, 8'h55);
        tick(20);
        checks++; if (log_a.size() !== 2) begin failures++; $display("FAIL stale_count got=%0d exp=2", log_a.size()); end
        checks++; if (log_a[0] !== 23'd3) begin failures++; $display("FAIL stale_a0 got=%h exp=3", log_a[0]); end
        checks++; if (log_ds[0] !== 2'b01) begin failures++; $display("FAIL stale_ds0 got=%b exp=01", log_ds[0]); end
        checks++; if (log_d[0] !== 16'h4444) begin failures++; $display("FAIL stale_d0 got=%h exp=4444", log_d[0]); end
        checks++; if (log_a[1] !== 23'd4) begin failures++; $display("FAIL stale_a1 got=%h exp=4", log_a[1]); end
        checks++; if (log_ds[1] !== 2'b10) begin failures++; $display("FAIL stale_ds1 got=%b exp=10", log_ds[1]); end
        checks++; if (log_d[1] !== 16'h5555) begin failures++; $display("FAIL stale_d1 got=%h exp=5555", log_d[1]); end
        dl_end();
        tick(20);
    endtask

    task automatic test_other_index();
        clear_log();
        dl_begin(8'd1);
        checks++; if (rom_loaded !== 1'b1) begin failures++; $display("FAIL index_loaded_kept got=%b exp=1", rom_loaded); end
        send_byte(25'd0, 8'h77);
        send_byte(25'd1, 8'h88);
        dl_end();
        tick(20);
        checks++; if (log_a.size() !== 0) begin failures++; $display("FAIL index_no_req got=%0d exp=0", log_a.size()); end
        checks++; if (rom_loaded !== 1'b1) begin failures++; $display("FAIL index_loaded got=%b exp=1", rom_loaded); end
    endtask

    task automatic test_overflow();
        logic [24:0] addr;
        clear_log();
        stab_err = 0;
        ack_hold = 1'b1;
        dl_begin(8'd0);
        for (int k = 0; k < 6; k++) begin
            addr = 25'h100 + 25'(2 * k);
            send_byte(addr, 8'(k));
            send_byte(addr + 25'd1, 8'(8'hA0 + k));
        end
        tick(5);
        checks++; if (log_a.size() !== 1) begin failures++; $display("FAIL ovf_one_issued got=%0d exp=1", log_a.size()); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        tick(20);
        ack_hold = 1'b0;
        dl_end();
        tick(60);
        checks++; if (log_a.size() !== 5) begin failures++; $display("FAIL ovf_count got=%0d exp=5", log_a.size()); end
        checks++; if (log_a[0] !== 23'h80) begin failures++; $display("FAIL ovf_a0 got=%h exp=80", log_a[0]); end
        checks++; if (log_a[4] !== 23'h84) begin failures++; $display("FAIL ovf_a4 got=%h exp=84", log_a[4]); end
        checks++; if (log_d[4] !== 16'hA404) begin failures++; $display("FAIL ovf_d4 got=%h exp=a404", log_d[4]); end
        checks++; if (stab_err !== 0) begin failures++; $display("FAIL ovf_wait_stable got=%0d exp=0", stab_err); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        checks++; if (rom_loaded !== 1'b1) begin failures++; $display("FAIL ovf_loaded got=%b exp=1", rom_loaded); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        ack_hold = 1'b1;
        dl_begin(8'd0);
        send_byte(25'h20, 8'h5A);
        send_byte(25'h21, 8'hA5);
        tick(6);
        checks++; if (log_a.size() !== 1) begin failures++; $display("FAIL rmid_issued got=%0d exp=1", log_a.size()); end
        checks++; if (log_d[0] !== 16'hA55A) begin failures++; $display("FAIL rmid_d got=%h exp=a55a", log_d[0]); end
        ioctl_download = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if (port1_req !== 1'b0) begin failures++; $display("FAIL rmid_req got=%b exp=0", port1_req); end
        checks++; if (port1_a !== 23'd0) begin failures++; $display("FAIL rmid_a got=%h exp=0", port1_a); end
        checks++; if (port1_ds !== 2'b00) begin failures++; $display("FAIL rmid_ds got=%b exp=00", port1_ds); end
        checks++; if (port1_d !== 16'h0000) begin failures++; $display("FAIL rmid_d0 got=%h exp=0000", port1_d); end
        checks++; if (port1_we !== 1'b0) begin failures++; $display("FAIL rmid_we got=%b exp=0", port1_we); end
        checks++; if (rom_loaded !== 1'b0) begin failures++; $display("FAIL rmid_loaded got=%b exp=0", rom_loaded); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rmid_overflow got=%b exp=0", overflow); end
        ack_poke = 1'b1;
        tick(2);
        ack_poke = 1'b0;
        reset_n = 1'b1;
        clear_log();
        dl_begin(8'd0);
        send_byte(25'h40, 8'h66);
        send_byte(25'h41, 8'h99);
        tick(15);
        checks++; if (log_a.size() !== 0) begin failures++; $display("FAIL rmid_blocked got=%0d exp=0", log_a.size()); end
        checks++; if (port1_req !== 1'b0) begin failures++; $display("FAIL rmid_req_blocked got=%b exp=0", port1_req); end
        ack_hold = 1'b0;
        tick(15);
        checks++; if (log_a.size() !== 1) begin failures++; $display("FAIL rmid_count got=%0d exp=1", log_a.size()); end
        checks++; if (log_a[0] !== 23'h20) begin failures++; $display("FAIL rmid_a_new got=%h exp=20", log_a[0]); end
        checks++; if (log_ds[0] !== 2'b11) begin failures++; $display("FAIL rmid_ds_new got=%b exp=11", log_ds[0]); end
        checks++; if (log_d[0] !== 16'h9966) begin failures++; $display("FAIL rmid_d_new got=%h exp=9966", log_d[0]); end
        dl_end();
        tick(20);
        checks++; if (rom_loaded !== 1'b1) begin failures++; $display("FAIL rmid_loaded_end got=%b exp=1", rom_loaded); end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ack_hold       = 1'b0;
        ack_poke       = 1'b0;
        test_reset();
        test_merge();
        test_odd_only();
        test_flush();
        test_stale_hold();
        test_other_index();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
